// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU.
// The decoder, hazard unit and execute stage all import this package.
package cpu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  // Bit of the 3-bit EX control word that selects the immediate as operand 2
  localparam int ALU_SRC_BIT = 2;

endpackage

// File: rtl/alu16.sv
// Purely combinational ALU: AND, ADD, SUB and PASS of operand b.
// Arithmetic wraps modulo 2^WIDTH; no flags are produced.
module alu16
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND:  y = a & b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_PASS: y = b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand-2 select, ALU, and the EX/MEM pipeline register
// holding the ALU result and the store data.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Immediate1,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       signals,
  output logic [WIDTH-1:0] AluResult,
  output logic [WIDTH-1:0] DataMemory
);

  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic [WIDTH-1:0] data_memory_d, data_memory_q;

  assign op2 = signals[ALU_SRC_BIT] ? Immediate1 : B;

  alu16 #(.WIDTH(WIDTH)) u_alu (
    .a  (A),
    .b  (op2),
    .op (signals[1:0]),
    .y  (alu_y)
  );

  // Store data is always the raw register B, never the muxed operand
  always_comb begin
    alu_result_d  = alu_y;
    data_memory_d = B;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q  <= '0;
      data_memory_q <= '0;
    end else begin
      alu_result_q  <= alu_result_d;
      data_memory_q <= data_memory_d;
    end
  end

  assign AluResult  = alu_result_q;
  assign DataMemory = data_memory_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases followed by randomized
// traffic compared against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Immediate1;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  signals;
  logic [15:0] AluResult;
  logic [15:0] DataMemory;

  int passCount  = 0;
  int checkCount = 0;

  logic [15:0] expAlu;
  logic [15:0] expMem;

  always #5 clk = ~clk;

  exe_stage #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .Immediate1 (Immediate1),
    .A          (A),
    .B          (B),
    .signals    (signals),
    .AluResult  (AluResult),
    .DataMemory (DataMemory)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Reference result computed with plain integer arithmetic, wrapped to 16 bits
  function automatic logic [15:0] refModel(input logic [15:0] imm, input logic [15:0] a,
                                           input logic [15:0] b, input logic [2:0] sig);
    int ia, io2, r;
    ia  = int'(a);
    io2 = sig[2] ? int'(imm) : int'(b);
    case (sig[1:0])
      2'd0:    r = int'(a & (sig[2] ? imm : b));
      2'd1:    r = (ia + io2) % 65536;
      2'd2:    r = (ia - io2 + 65536) % 65536;
      default: r = io2;
    endcase
    return r[15:0];
  endfunction

  // Drives one cycle of inputs; optionally confirms outputs do not change
  // before the edge, then checks the registered result after it.
  task automatic applyStimulus(input string tag, input logic rst, input logic [15:0] imm,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] sig, input bit checkHold);
    reset      = rst;
    Immediate1 = imm;
    A          = a;
    B          = b;
    signals    = sig;
    #2;
    if (checkHold) begin
      checkOutput({tag, "_holdAlu"}, AluResult, expAlu);
      checkOutput({tag, "_holdMem"}, DataMemory, expMem);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      expAlu = 16'h0000;
      expMem = 16'h0000;
    end else begin
      expAlu = refModel(imm, a, b, sig);
      expMem = b;
    end
    checkOutput({tag, "_alu"}, AluResult, expAlu);
    checkOutput({tag, "_mem"}, DataMemory, expMem);
  endtask

  initial begin
    logic [15:0] ra, rb, ri;
    logic [2:0]  rs;
    logic        rr;

    $display("[TB] starting exe_stage bench");

    // Reset, then release with the same ADD inputs
    applyStimulus("resetHold", 1'b1, 16'h0000, 16'h1234, 16'h5678, 3'b001, 1'b0);
    checkOutput("resetAluZero", AluResult, 16'h0000);
    applyStimulus("resetRelease", 1'b0, 16'h0000, 16'h1234, 16'h5678, 3'b001, 1'b1);
    checkOutput("releaseAdd", AluResult, 16'h68AC);

    // ADD register: result must not appear before the edge
    applyStimulus("addReg", 1'b0, 16'h0000, 16'd5, 16'd7, 3'b001, 1'b1);
    checkOutput("addRegValue", AluResult, 16'd12);

    // Immediate operand with wrap-around
    applyStimulus("immWrap", 1'b0, 16'h0002, 16'hFFFF, 16'hAAAA, 3'b101, 1'b1);
    checkOutput("immWrapValue", AluResult, 16'h0001);
    checkOutput("immWrapStore", DataMemory, 16'hAAAA);

    // SUB producing a negative result
    applyStimulus("subNeg", 1'b0, 16'h0000, 16'd3, 16'd5, 3'b010, 1'b1);
    checkOutput("subNegValue", AluResult, 16'hFFFE);

    // AND then PASS on consecutive edges
    applyStimulus("andOp", 1'b0, 16'h0000, 16'hF0F0, 16'h3C3C, 3'b000, 1'b1);
    checkOutput("andValue", AluResult, 16'h3030);
    applyStimulus("passOp", 1'b0, 16'h0042, 16'hF0F0, 16'h3C3C, 3'b111, 1'b1);
    checkOutput("passValue", AluResult, 16'h0042);
    checkOutput("passStore", DataMemory, 16'h3C3C);

    // Stream of ADDs with a one-cycle reset pulse in the middle
    applyStimulus("streamAdd0", 1'b0, 16'h0000, 16'd100, 16'd1, 3'b001, 1'b1);
    applyStimulus("streamAdd1", 1'b0, 16'h0000, 16'd200, 16'd2, 3'b001, 1'b1);
    applyStimulus("streamPulse", 1'b1, 16'h0000, 16'd300, 16'd3, 3'b001, 1'b1);
    checkOutput("streamPulseZero", AluResult, 16'h0000);
    applyStimulus("streamAdd3", 1'b0, 16'h0000, 16'd400, 16'd4, 3'b001, 1'b1);
    checkOutput("streamAfterPulse", AluResult, 16'd404);
    applyStimulus("streamAdd4", 1'b0, 16'h0000, 16'd500, 16'd5, 3'b001, 1'b1);

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ri = 16'($urandom);
      rs = 3'($urandom_range(0, 7));
      rr = ($urandom_range(0, 15) == 0);
      applyStimulus("random", rr, ri, ra, rb, rs, 1'b1);
    end

    // Boundary operands for every op/source combination
    for (int s = 0; s < 8; s++) begin
      applyStimulus("edgeMax", 1'b0, 16'hFFFF, 16'hFFFF, 16'h8000, 3'(s), 1'b1);
      applyStimulus("edgeZero", 1'b0, 16'h0001, 16'h0000, 16'hFFFF, 3'(s), 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
